// File: rtl/read_dat_extd_pkg.sv
// rtl/read_dat_extd_pkg.sv - shared types and constants for the read-data lane extender
package read_dat_extd_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_NONE = 2'd3
    } size_e;

    localparam int LANES_WORD  = 1;
    localparam int LANES_HALF  = 2;
    localparam int LANES_BYTE  = 4;

    localparam int ELEM_W_WORD = 32;
    localparam int ELEM_W_HALF = 16;
    localparam int ELEM_W_BYTE = 8;

    typedef struct packed {
        size_e      size;
        logic [1:0] lane;
        logic       sgn;
    } req_info_t;

endpackage

// File: rtl/read_dat_extd_fifo.sv
// rtl/read_dat_extd_fifo.sv - in-order request-info queue with full/empty and count
module read_dat_extd_fifo
    import read_dat_extd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  req_info_t                  push_dat_i,
    input  logic                       pop_i,
    output req_info_t                  pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    req_info_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/read_dat_extd.sv
// rtl/read_dat_extd.sv - load lane select and extend; READ_DAT_EXTD_SIGN_EN enables sign extension
module read_dat_extd
    import read_dat_extd_pkg::*;
#(
    parameter int WIDTH_TYPE_NUM = 3,
    parameter int WIDTH_ADDR     = 32,
    parameter int WIDTH_DATA_IN  = 32,
    parameter int WIDTH_DATA_OUT = 32,
    parameter int ADDR_TYPE      = 1,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iReqVld,
    output logic                      oReqRdy,
    input  logic [WIDTH_TYPE_NUM-1:0] iEn,
    input  logic [WIDTH_ADDR-1:0]     iAddr,
    input  logic                      iSigned,
    input  logic                      iRspVld,
    output logic                      oRspRdy,
    input  logic [WIDTH_DATA_IN-1:0]  iRspDat,
    output logic                      oVld,
    input  logic                      iRdy,
    output logic [WIDTH_DATA_OUT-1:0] oDat
);

    req_info_t                   req_info, pop_info;
    logic                        full, empty;
    logic [$clog2(DEPTH):0]      count;
    logic                        push, pop;
    logic                        half_ok, byte_ok;
    logic [1:0]                  half_lane, byte_lane;
    logic                        sgn_en;
    logic [ELEM_W_HALF-1:0]      half_el;
    logic [ELEM_W_BYTE-1:0]      byte_el;
    logic [WIDTH_DATA_OUT-1:0]   ext_dat;
    logic                        vld_q, vld_d;
    logic [WIDTH_DATA_OUT-1:0]   dat_q, dat_d;

    generate
        if (ADDR_TYPE == 1) begin : g_lsb_lane
            assign half_ok   = (iAddr < WIDTH_ADDR'(LANES_HALF));
            assign byte_ok   = (iAddr < WIDTH_ADDR'(LANES_BYTE));
            assign half_lane = {1'b0, iAddr[0]};
            assign byte_lane = iAddr[1:0];
        end else begin : g_msb_lane
            // Lane fields sit in the top address bits; only the low bits of each field select a lane.
            wire unused_addr = ^iAddr;
            assign half_ok   = 1'b1;
            assign byte_ok   = 1'b1;
            assign half_lane = {1'b0, iAddr[WIDTH_ADDR-2]};
            assign byte_lane = iAddr[WIDTH_ADDR-2 -: 2];
        end
    endgenerate

    always_comb begin
        req_info.size = SZ_NONE;
        req_info.lane = 2'd0;
        req_info.sgn  = 1'b0;
        if (iEn[0]) begin
            req_info.size = SZ_WORD;
        end else if (iEn[1]) begin
            if (half_ok) begin
                req_info.size = SZ_HALF;
                req_info.lane = half_lane;
            end
        end else if (iEn[2]) begin
            if (byte_ok) begin
                req_info.size = SZ_BYTE;
                req_info.lane = byte_lane;
            end
        end
`ifdef READ_DAT_EXTD_SIGN_EN
        req_info.sgn = iSigned;
`endif
    end

`ifdef READ_DAT_EXTD_SIGN_EN
    assign sgn_en = pop_info.sgn;
`else
    wire unused_sgn = ^{iSigned, pop_info.sgn};
    assign sgn_en = 1'b0;
`endif

    assign oReqRdy = ~full;
    assign push    = iReqVld & ~full;
    // The output register must be free or draining before a new response is taken.
    assign oRspRdy = ~empty & (~vld_q | iRdy);
    assign pop     = iRspVld & oRspRdy;

    read_dat_extd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (req_info),
        .pop_i      (pop),
        .pop_dat_o  (pop_info),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    wire unused_count = ^count;

    assign half_el = iRspDat[ELEM_W_HALF*pop_info.lane[0] +: ELEM_W_HALF];
    assign byte_el = iRspDat[ELEM_W_BYTE*pop_info.lane +: ELEM_W_BYTE];

    always_comb begin
        ext_dat = '0;
        case (pop_info.size)
            SZ_WORD: ext_dat = WIDTH_DATA_OUT'(iRspDat);
            SZ_HALF: ext_dat = {{(WIDTH_DATA_OUT-ELEM_W_HALF){sgn_en & half_el[ELEM_W_HALF-1]}}, half_el};
            SZ_BYTE: ext_dat = {{(WIDTH_DATA_OUT-ELEM_W_BYTE){sgn_en & byte_el[ELEM_W_BYTE-1]}}, byte_el};
            default: ext_dat = '0;
        endcase
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (pop) begin
            vld_d = 1'b1;
            dat_d = ext_dat;
        end else if (iRdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign oVld = vld_q;
    assign oDat = dat_q;

endmodule

// File: tb/tb_read_dat_extd.sv
// tb/tb_read_dat_extd.sv - directed self-checking bench for read_dat_extd
module tb_read_dat_extd;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReqVld;
    logic        oReqRdy;
    logic [2:0]  iEn;
    logic [31:0] iAddr;
    logic        iSigned;
    logic        iRspVld;
    logic        oRspRdy;
    logic [31:0] iRspDat;
    logic        oVld;
    logic        iRdy;
    logic [31:0] oDat;

    int tests  = 0;
    int errors = 0;

    localparam logic [2:0] EN_WORD = 3'b011;
    localparam logic [2:0] EN_HALF = 3'b010;
    localparam logic [2:0] EN_BYTE = 3'b100;

`ifdef READ_DAT_EXTD_SIGN_EN
    localparam logic [31:0] EXP_SBYTE = 32'hFFFF_FFAA;
    localparam logic [31:0] EXP_SHALF = 32'hFFFF_8899;
`else
    localparam logic [31:0] EXP_SBYTE = 32'h0000_00AA;
    localparam logic [31:0] EXP_SHALF = 32'h0000_8899;
`endif

    always #5 clk = ~clk;

    read_dat_extd dut (
        .clk     (clk),
        .rst     (rst),
        .iReqVld (iReqVld),
        .oReqRdy (oReqRdy),
        .iEn     (iEn),
        .iAddr   (iAddr),
        .iSigned (iSigned),
        .iRspVld (iRspVld),
        .oRspRdy (oRspRdy),
        .iRspDat (iRspDat),
        .oVld    (oVld),
        .iRdy    (iRdy),
        .oDat    (oDat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] en, input logic [31:0] addr, input logic sgn);
        iReqVld = 1'b1;
        iEn     = en;
        iAddr   = addr;
        iSigned = sgn;
        step();
        iReqVld = 1'b0;
    endtask

    task automatic resp(input logic [31:0] dat);
        int n = 0;
        iRspVld = 1'b1;
        iRspDat = dat;
        while (!oRspRdy && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("resp_timeout", 32'd0, 32'd1);
        step();
        iRspVld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iReqVld = 1'b0; iEn = '0; iAddr = '0; iSigned = 1'b0;
        iRspVld = 1'b0; iRspDat = '0; iRdy = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_vld", {31'd0, oVld}, 32'd0);
        check("rst_dat", oDat, 32'd0);
        check("rst_reqrdy", {31'd0, oReqRdy}, 32'd1);
        check("rst_rsprdy", {31'd0, oRspRdy}, 32'd0);

        // Lane extraction
        push(EN_BYTE, 32'd1, 1'b0);
        resp(32'h8899_AABB);
        check("byte_u_vld", {31'd0, oVld}, 32'd1);
        check("byte_u", oDat, 32'h0000_00AA);
        step();
        check("vld_clear", {31'd0, oVld}, 32'd0);
        push(EN_BYTE, 32'd1, 1'b1);
        resp(32'h8899_AABB);
        check("byte_s", oDat, EXP_SBYTE);
        push(EN_HALF, 32'd1, 1'b1);
        resp(32'h8899_AABB);
        check("half_s", oDat, EXP_SHALF);
        push(EN_WORD, 32'd0, 1'b1);
        resp(32'h8899_AABB);
        check("word", oDat, 32'h8899_AABB);

        // Out-of-range lane and no width type
        push(EN_BYTE, 32'd5, 1'b0);
        push(3'b000, 32'd0, 1'b0);
        resp(32'h8899_AABB);
        check("byte_oor", oDat, 32'd0);
        check("byte_oor_vld", {31'd0, oVld}, 32'd1);
        resp(32'h1234_5678);
        check("no_type", oDat, 32'd0);
        check("empty_rsprdy", {31'd0, oRspRdy}, 32'd0);

        // Response with nothing queued stalls
        step();
        iRspVld = 1'b1; iRspDat = 32'hDEAD_BEEF;
        step(); step();
        check("stall_vld", {31'd0, oVld}, 32'd0);
        iRspVld = 1'b0;

        // Queue full, rejected extra push, order preserved
        for (int i = 0; i < 4; i++) push(EN_BYTE, 32'(i), 1'b0);
        check("full_reqrdy", {31'd0, oReqRdy}, 32'd0);
        push(EN_WORD, 32'd0, 1'b0);
        resp(32'h4433_2211);
        check("full_first", oDat, 32'h0000_0011);
        check("unfull_reqrdy", {31'd0, oReqRdy}, 32'd1);
        resp(32'h4433_2211);
        check("full_second", oDat, 32'h0000_0022);
        resp(32'h4433_2211);
        check("full_third", oDat, 32'h0000_0033);
        resp(32'h4433_2211);
        check("full_fourth", oDat, 32'h0000_0044);
        check("full_drained", {31'd0, oRspRdy}, 32'd0);

        // Backpressure then back-to-back release
        for (int i = 0; i < 3; i++) push(EN_BYTE, 32'(i), 1'b0);
        iRdy = 1'b0;
        iRspVld = 1'b1; iRspDat = 32'h4433_2211;
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_dat", oDat, 32'h0000_0011);
            check("bp_rsprdy", {31'd0, oRspRdy}, 32'd0);
            step();
        end
        check("bp_vld", {31'd0, oVld}, 32'd1);
        iRdy = 1'b1;
        step();
        check("rel_second", oDat, 32'h0000_0022);
        step();
        check("rel_third", oDat, 32'h0000_0033);
        iRspVld = 1'b0;
        step();
        check("rel_idle", {31'd0, oVld}, 32'd0);

        // Push and pop in the same cycle
        push(EN_BYTE, 32'd3, 1'b0);
        iReqVld = 1'b1; iEn = EN_BYTE; iAddr = 32'd0; iSigned = 1'b0;
        iRspVld = 1'b1; iRspDat = 32'hDDCC_BBAA;
        step();
        iReqVld = 1'b0; iRspVld = 1'b0;
        check("pp_first", oDat, 32'h0000_00DD);
        resp(32'hDDCC_BBAA);
        check("pp_second", oDat, 32'h0000_00AA);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) push(EN_BYTE, 32'(i), 1'b0);
        resp(32'hDDCC_BBAA);
        check("pre_rst_vld", {31'd0, oVld}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_vld", {31'd0, oVld}, 32'd0);
        check("mid_rst_dat", oDat, 32'd0);
        check("mid_rst_rsprdy", {31'd0, oRspRdy}, 32'd0);
        check("mid_rst_reqrdy", {31'd0, oReqRdy}, 32'd1);
        push(EN_HALF, 32'd0, 1'b0);
        resp(32'hDDCC_BBAA);
        check("post_rst_half", oDat, 32'h0000_BBAA);
        check("post_rst_empty", {31'd0, oRspRdy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
